// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants for the PS/2 keyboard receiver.
//   - Receive FSM state encoding (2-bit, legacy-compatible localparams).
//   - Register offsets (bus address bits [3:2]).
//   - STATUS bit positions and a helper that assembles the STATUS byte.
package ps2_pkg;

    // Receive FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Register offsets, selected by addr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    // STATUS bit positions
    localparam int STAT_NEMPTY = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_OVF    = 2;
    localparam int STAT_PERR   = 3;
    localparam int STAT_FERR   = 4;

    function automatic logic [7:0] pack_status(
        input logic ferr,
        input logic perr,
        input logic ovf,
        input logic full,
        input logic nempty
    );
        logic [7:0] s;
        s = 8'h00;
        s[STAT_FERR]   = ferr;
        s[STAT_PERR]   = perr;
        s[STAT_OVF]    = ovf;
        s[STAT_FULL]   = full;
        s[STAT_NEMPTY] = nempty;
        return s;
    endfunction

endpackage

// File: rtl/ps2kbd_if.sv
// ps2kbd_if: CPU-side memory-mapped bus of the PS/2 keyboard device.
//   r_en   : read strobe, already decoded by busdev
//   r_addr : read address, bits [3:2] select the register
//   r_data : registered read data, valid one cycle after a read strobe
//   w_en   : write strobe, already decoded by busdev
//   w_addr : write address, bits [3:2] select the register
//   w_data : write data, bits [7:0] used
//
// Handshake: there is no valid/ready pair. A strobe is accepted in every
// cycle it is high (the device never stalls); a read's side effect (FIFO
// pop) is taken only on the rising edge of r_en, and r_data holds the
// captured value until the next read strobe edge.
interface ps2kbd_if;
    logic        r_en;
    logic [31:0] r_addr;
    logic [7:0]  r_data;
    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_data;

    modport master (
        output r_en, r_addr, w_en, w_addr, w_data,
        input  r_data
    );

    modport slave (
        input  r_en, r_addr, w_en, w_addr, w_data,
        output r_data
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO.
//   clk, rst : clock, synchronous active-high reset (pointers only)
//   push/din : write request and data; ignored when full unless a pop
//              happens in the same cycle
//   pop      : read request; ignored when empty
//   dout     : current head entry (combinational)
//   full, empty, count : occupancy status
// Pointers carry one extra MSB so full (MSBs differ, rest equal) and
// empty (all equal) are distinguishable without a separate counter.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // is still accepted then.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2kbd.sv
// ps2kbd: memory-mapped PS/2 keyboard receiver (cpuclk domain).
//   clk, rst  : cpuclk, synchronous active-high reset
//   bus       : ps2kbd_if.slave, CPU read/write window
//   ps2_clk   : raw PS/2 clock pin (asynchronous)
//   ps2_data  : raw PS/2 data pin (asynchronous)
//   irq       : high while the scan-code FIFO is not empty
//   dbg_state : current receive FSM state (ST_* encoding)
// Registers (addr[3:2]): 0 DATA (read pops head, 0x00 if empty),
// 1 STATUS {3'b0,ferr,perr,ovf,full,nempty} / W1C of [4:2], 2 COUNT,
// 3 reads 0x00.
module ps2kbd
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 8000
) (
    input  logic       clk,
    input  logic       rst,
    ps2kbd_if.slave    bus,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       irq,
    output logic [1:0] dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    // ---------------- synchronisers and falling-edge detect ----------------
    logic clk_meta, clk_sync, clk_prev;
    logic dat_meta, dat_sync;
    logic fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_data;
            dat_sync <= dat_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    // ---------------- receive FSM ----------------
    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tcnt       <= '0;
        end else if (state == ST_IDLE) begin
            tcnt <= '0;
            // A high data line at a falling edge is noise, not a start bit.
            if (fall && !dat_sync) begin
                state  <= ST_SHIFT;
                bitcnt <= '0;
            end
        end else if (fall) begin
            tcnt <= '0;
            case (state)
                ST_SHIFT: begin
                    shreg  <= {dat_sync, shreg[7:1]};   // LSB first
                    bitcnt <= bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state <= ST_PARITY;
                end
                ST_PARITY: begin
                    parity_bit <= dat_sync;
                    state      <= ST_STOP;
                end
                default: begin
                    state <= ST_IDLE;                    // ST_STOP
                end
            endcase
        end else if (tcnt == TMAX) begin
            // Stalled frame: drop it silently.
            state <= ST_IDLE;
            tcnt  <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign dbg_state = state;

    logic frame_done, parity_ok, stop_ok;
    logic rx_push, perr_set, ferr_set;

    assign frame_done = (state == ST_STOP) & fall;
    assign parity_ok  = ^{shreg, parity_bit};   // odd parity over 9 bits
    assign stop_ok    = dat_sync;
    assign rx_push    = frame_done & parity_ok & stop_ok;
    assign perr_set   = frame_done & ~parity_ok;
    assign ferr_set   = frame_done & ~stop_ok;

    // ---------------- bus decode ----------------
    logic [1:0] r_off, w_off;
    logic       r_en_d;
    logic       rd_rise;

    assign r_off   = bus.r_addr[3:2];
    assign w_off   = bus.w_addr[3:2];
    assign rd_rise = bus.r_en & ~r_en_d;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.r_addr[31:4], bus.r_addr[1:0],
                               bus.w_addr[31:4], bus.w_addr[1:0],
                               bus.w_data[31:8], bus.w_data[1:0],
                               bus.w_data[7:5]};

    // ---------------- FIFO ----------------
    logic [7:0]  fifo_dout;
    logic        fifo_full, fifo_empty, fifo_pop;
    logic [AW:0] fifo_count;

    assign fifo_pop = rd_rise & (r_off == REG_DATA) & ~fifo_empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (shreg),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- sticky flags ----------------
    logic       ovf, perr, ferr;
    logic       ovf_set;
    logic [2:0] w1c;

    // Full with no simultaneous pop means the byte is dropped.
    assign ovf_set = rx_push & fifo_full & ~fifo_pop;
    assign w1c     = (bus.w_en && w_off == REG_STATUS) ? bus.w_data[4:2] : 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf  <= 1'b0;
            perr <= 1'b0;
            ferr <= 1'b0;
        end else begin
            // Set wins over a same-cycle clear.
            ovf  <= (ovf  & ~w1c[0]) | ovf_set;
            perr <= (perr & ~w1c[1]) | perr_set;
            ferr <= (ferr & ~w1c[2]) | ferr_set;
        end
    end

    // ---------------- registered read data ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_d     <= 1'b0;
            bus.r_data <= 8'h00;
        end else begin
            r_en_d <= bus.r_en;
            if (rd_rise) begin
                case (r_off)
                    REG_DATA:   bus.r_data <= fifo_empty ? 8'h00 : fifo_dout;
                    REG_STATUS: bus.r_data <= pack_status(ferr, perr, ovf,
                                                          fifo_full, ~fifo_empty);
                    REG_COUNT:  bus.r_data <= 8'(fifo_count);
                    default:    bus.r_data <= 8'h00;
                endcase
            end
        end
    end

    assign irq = ~fifo_empty;

endmodule

// File: doc/ps2kbd.md
Name: ps2kbd

Overview:
- Memory-mapped PS/2 keyboard receiver on the CPU data bus; the input-direction counterpart to the write-only terminal device.
- Samples the PS/2 clock/data lines, deframes 11-bit device-to-host frames and checks odd parity.
- Queues received scan codes in a FIFO that the CPU reads through a busdev-decoded window.
- Runs entirely in the cpuclk domain.

Parameters:
- FIFO_DEPTH, 8: scan-code FIFO entries; power of 2, at least 2.
- TIMEOUT, 8000: cpuclk cycles without a PS/2 falling edge before a partial frame is aborted (2 ms at 4 MHz).

Ports:
- clk  in  1  cpuclk.
- rst  in  1  synchronous reset, active-high.
- bus_r_en  in  1  read strobe, already decoded by busdev.
- bus_r_addr  in  32  read address; only [3:2] is used.
- bus_r_data  out  8  registered read data.
- bus_w_en  in  1  write strobe, already decoded by busdev.
- bus_w_addr  in  32  write address; only [3:2] is used.
- bus_w_data  in  32  write data; only [7:0] is used.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data  in  1  raw PS/2 data pin (asynchronous).
- irq  out  1  high while the FIFO is not empty.

Behaviour:
- Synchronisers:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser; synchroniser flops reset to 1.
  - A third ps2_clk flop provides falling-edge detect: fall = prev & ~cur.
- Receive FSM: IDLE, SHIFT, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit), go to SHIFT with bitcnt=0. On fall with data=1, stay in IDLE (line noise).
  - SHIFT: on each fall, shift data in LSB-first; after the 8th bit go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, if data=1 and XOR(byte, parity)=1, push the byte. Otherwise set perr (parity wrong) or ferr (stop bit 0) and drop the byte. Return to IDLE in both cases.
- Timeout: a counter clears on every fall and on entry to IDLE. In any non-IDLE state, reaching TIMEOUT-1 forces IDLE and discards the partial frame silently, setting no flag.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH)+1 bits. The extra MSB distinguishes full from empty.
  - Push while full drops the new byte, keeps the old data and sets the sticky ovf flag.
  - A push and a pop in the same cycle both take effect; count is unchanged. When full, the pop makes room and the push is accepted.
- Register map (offset = addr[3:2]):
  - 0, read: DATA, the FIFO head; the read pops the entry. If empty, returns 0x00 with no pop.
  - 1, read: STATUS = {3'b0, ferr, perr, ovf, full, nempty}.
  - 1, write: W1C. Bits [4:2] of bus_w_data clear ferr/perr/ovf. A clear and a set in the same cycle leaves the flag set.
  - 2, read: COUNT, the FIFO occupancy.
  - 3: reads 0x00; writes are ignored.
- Read timing:
  - bus_r_data is registered and valid one cycle after bus_r_en.
  - It holds its value until the next read strobe.
  - The pop happens only on the rising edge of bus_r_en (en & ~en_d), so a strobe held for several cycles pops exactly once.
- Reset values:
  - bus_r_data = 0, irq = 0.
  - FIFO pointers = 0; all flags = 0.
  - FSM in IDLE; timeout counter = 0.
- Reset mid-frame: the FSM returns to IDLE and the partial frame is lost. The next start bit is received normally.
- irq = nempty, driven combinationally from the registered pointers.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state encoding.
  - Register offset constants REG_DATA=0, REG_STATUS=1, REG_COUNT=2.
  - STATUS bit indices.
- One sub-module: sync_fifo, a parameterised-depth FIFO with push, pop, full, empty and count outputs, reusable by later UART-RX devices.
- Frame deframer and bus decode stay in ps2kbd.

Test Plan:
- Single frame, byte 0x1C with parity 0 (odd total), bit period 300 cycles -> STATUS reads 0x01 and COUNT reads 1. A DATA read returns 0x1C one cycle after the strobe; a following STATUS read returns 0x00 and irq drops.
- Parity error: send 0x1C with parity 1 -> no push, STATUS = 0x08. Write 0x08 to offset 1 -> STATUS = 0x00.
- Overflow: send 9 valid frames 0x01..0x09 with FIFO_DEPTH=8 -> STATUS = 0x07 (ovf, full, nempty). Eight DATA reads return 0x01..0x08; the ninth returns 0x00.
- Timeout: start bit plus 4 data bits, then idle for 8000 cycles -> FSM returns to IDLE with no flags set. A following full 0xF0 frame is received correctly.
- Held strobe: bus_r_en held high for 5 cycles on DATA with 2 bytes queued -> exactly one pop, COUNT = 1.
- Reset mid-SHIFT after 3 bits -> all outputs return to reset values. The next 0x5A frame is received correctly.
